// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state, round count, word type and word/byte helpers.
package aes_pkg;

  localparam int unsigned AES_NR = 10;

  typedef logic [31:0] aes_word_t;

  typedef enum logic {
    StIdle   = 1'b0,
    StExpand = 1'b1
  } aes_state_e;

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon.sv
// Round-constant generator: restarts at 01 on start_flag, otherwise doubles in GF(2^8) each cycle.
module aes_rcon
  import aes_pkg::*;
(
  input  logic      clk,
  input  logic      start_flag,
  output aes_word_t out
);

  logic [7:0] rc_q, rc_d;

  always_comb begin
    rc_d = start_flag ? 8'h01 : xtime(rc_q);
  end

  // No reset: the value is only consumed after a start has loaded it.
  always_ff @(posedge clk) begin
    rc_q <= rc_d;
  end

  assign out = {rc_q, 24'h000000};

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// AES-128 key expansion controller: streams round keys 0..10, one per cycle, using an external S-box.
module aes_key_expand_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         done,
  output aes_word_t    sb_in,
  input  aes_word_t    sb_out
);

  aes_state_e   state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] rk_out_q, rk_out_d;
  logic [3:0]   rk_round_q, rk_round_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         rk_valid_q, rk_valid_d;
  logic         done_q, done_d;

  logic         start_flag;
  aes_word_t    rcon;
  aes_word_t    temp, w0_n, w1_n, w2_n, w3_n;

  assign start_flag = (state_q == StIdle) && start;

  aes_rcon u_aes_rcon (
    .clk        (clk),
    .start_flag (start_flag),
    .out        (rcon)
  );

  assign sb_in = rot_word(key_q[31:0]);

  always_comb begin
    temp = sb_out ^ rcon;
    w0_n = key_q[127:96] ^ temp;
    w1_n = key_q[95:64]  ^ w0_n;
    w2_n = key_q[63:32]  ^ w1_n;
    w3_n = key_q[31:0]   ^ w2_n;
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    rk_out_d   = rk_out_q;
    rk_round_d = rk_round_q;
    cnt_d      = cnt_q;
    rk_valid_d = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StExpand;
          key_d      = key_in;
          rk_out_d   = key_in;
          rk_round_d = 4'd0;
          rk_valid_d = 1'b1;
          cnt_d      = 4'd1;
        end
      end
      StExpand: begin
        key_d      = {w0_n, w1_n, w2_n, w3_n};
        rk_out_d   = {w0_n, w1_n, w2_n, w3_n};
        rk_round_d = cnt_q;
        rk_valid_d = 1'b1;
        if (cnt_q == 4'(AES_NR)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      key_q      <= '0;
      rk_out_q   <= '0;
      rk_round_q <= '0;
      cnt_q      <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      rk_out_q   <= rk_out_d;
      rk_round_q <= rk_round_d;
      cnt_q      <= cnt_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == StExpand);
  assign rk_valid = rk_valid_q;
  assign rk_round = rk_round_q;
  assign rk_out   = rk_out_q;
  assign done     = done_q;

endmodule
